// File: rtl/choose_ctrl.sv
// Cursor/selection controller for the choose scene: button edges move a cursor on a
// 2x4 grid, a two-step confirm blinks the frame, and the pick is handed off via valid/ack.
module choose_ctrl #(
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int CONFIRM_TIMEOUT = 500_000_000,
  parameter int CNT_WIDTH       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scene_active,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  input  logic       chosen_ack,
  output logic [7:0] pokemon_id,
  output logic       frame_visible,
  output logic [7:0] chosen_id,
  output logic       chosen_valid
);

  typedef enum logic [2:0] {S_IDLE, S_BROWSE, S_CONFIRM, S_DONE, S_LOCKED} state_t;

  localparam logic [CNT_WIDTH-1:0] BLINK_LAST = CNT_WIDTH'(BLINK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'(CONFIRM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  // bit order is the event priority: confirm, cancel, up, down, left, right
  localparam int EV_CONFIRM = 0, EV_CANCEL = 1, EV_UP = 2, EV_DOWN = 3, EV_LEFT = 4, EV_RIGHT = 5;

  state_t               state_q, state_d;
  logic [7:0]           id_q, id_d;
  logic                 fv_q, fv_d;
  logic [7:0]           cid_q, cid_d;
  logic                 cv_q, cv_d;
  logic [CNT_WIDTH-1:0] blink_q, blink_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic [5:0]           hist_q, hist_d;
  logic [5:0]           lvl, ev;

  assign lvl = {btn_right, btn_left, btn_down, btn_up, btn_cancel, btn_confirm};
  assign ev  = lvl & ~hist_q;

  // cursor kept as a 0-based 3-bit index: bit 2 is the row, bits 1:0 the column
  function automatic logic [7:0] grid_move(input logic [7:0] id, input int dir);
    logic [2:0] idx;
    idx = 3'(id - 8'd1);
    case (dir)
      EV_UP, EV_DOWN: idx[2]   = ~idx[2];
      EV_LEFT:        idx[1:0] = idx[1:0] - 2'd1;
      EV_RIGHT:       idx[1:0] = idx[1:0] + 2'd1;
      default: ;
    endcase
    return {5'd0, idx} + 8'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    fv_d    = fv_q;
    cid_d   = cid_q;
    cv_d    = cv_q;
    blink_d = blink_q;
    tmo_d   = tmo_q;
    hist_d  = lvl;

    if (!scene_active && (state_q == S_BROWSE || state_q == S_CONFIRM || state_q == S_DONE)) begin
      state_d = S_IDLE;
      cv_d    = 1'b0;
      fv_d    = 1'b1;
      blink_d = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (scene_active) begin
          state_d = S_BROWSE;
          cid_d   = 8'd0;
        end
        S_BROWSE: begin
          if (ev[EV_CONFIRM]) begin
            state_d = S_CONFIRM;
            blink_d = '0;
            tmo_d   = '0;
            fv_d    = 1'b1;
          end else if (ev[EV_CANCEL]) begin
            id_d = id_q;
          end else if (ev[EV_UP])    id_d = grid_move(id_q, EV_UP);
          else if (ev[EV_DOWN])      id_d = grid_move(id_q, EV_DOWN);
          else if (ev[EV_LEFT])      id_d = grid_move(id_q, EV_LEFT);
          else if (ev[EV_RIGHT])     id_d = grid_move(id_q, EV_RIGHT);
        end
        S_CONFIRM: begin
          blink_d = '0;
          tmo_d   = '0;
          fv_d    = 1'b1;
          if (ev[EV_CONFIRM]) begin
            state_d = S_DONE;
            cid_d   = id_q;
            cv_d    = 1'b1;
          end else if (ev[EV_CANCEL] || tmo_q == TMO_LAST) begin
            state_d = S_BROWSE;
          end else begin
            tmo_d = tmo_q + CNT_ONE;
            if (blink_q == BLINK_LAST) fv_d = ~fv_q;
            else begin
              fv_d    = fv_q;
              blink_d = blink_q + CNT_ONE;
            end
          end
        end
        S_DONE: if (chosen_ack) begin
          cv_d    = 1'b0;
          state_d = S_LOCKED;
        end
        S_LOCKED: if (!scene_active) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= 8'd1;
      fv_q    <= 1'b1;
      cid_q   <= 8'd0;
      cv_q    <= 1'b0;
      blink_q <= '0;
      tmo_q   <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      fv_q    <= fv_d;
      cid_q   <= cid_d;
      cv_q    <= cv_d;
      blink_q <= blink_d;
      tmo_q   <= tmo_d;
      hist_q  <= hist_d;
    end
  end

  assign pokemon_id    = id_q;
  assign frame_visible = fv_q;
  assign chosen_id     = cid_q;
  assign chosen_valid  = cv_q;

endmodule
